ibex_mult_pext_seq: RTL and testbench
=====================================

Name: ibex_mult_pext_seq

Overview:
- Sequencer for the P-extension SIMD multiplier datapath (eight 8x8 kernels, 32x16 combine, shared accumulator).
- Sits between the EX-stage operator decode and the multiplier datapath.
- Per cycle it drives the kernel quadrant select and the B-operand sign enable, and it owns the 32-bit accumulator register.
- Sequences multi-pass 32x32 and accumulate (MAC) operations, and raises valid_o on the cycle the datapath result is final.

Parameters:
- ACC_RST_VAL, 32'h0000_0000, reset and initial value of the accumulator register.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- mult_en_i  in  1  request. Held high by EX until valid_o is seen.
- kill_i  in  1  flush of the current operation. Has priority over mult_en_i.
- mode_i  in  2  mult_pext_mode_e: M8x8, M16x16, M32x16, M32x32.
- crossed_i  in  1  crossed operand pairing requested.
- accum_i  in  1  MAC operation; needs an accumulate cycle.
- partial_i  in  32  datapath 32x16 upper word (bits [47:16]) of the current pass.
- quadrant_o  out  2  kernel B-operand quadrant select.
- b_sign_en_o  out  1  B-operand sign extension enable for the kernels.
- acc_phase_o  out  1  datapath selects accumulator + rd_val this cycle.
- accum_q_o  out  32  accumulator register value.
- busy_o  out  1  sequencer is in a state other than MP_FIRST.
- valid_o  out  1  datapath result is valid this cycle.

Behaviour:
- Reset: state = MP_FIRST, accum_q_o = ACC_RST_VAL, latched op fields = 0.
  - All outputs come out of reset at 0: busy_o, valid_o, acc_phase_o, quadrant_o = 2'b00, b_sign_en_o.
- States (mult_pext_fsm_e): MP_FIRST, MP_SECOND, MP_ACCUM.
- Control source:
  - In MP_FIRST, controls decode directly from mode_i/crossed_i/accum_i.
  - Whenever mult_en_i is high in MP_FIRST, those fields are latched (mode_q, crossed_q, accum_q_flag).
  - MP_SECOND and MP_ACCUM use only the latched fields; input changes are ignored.
- Quadrant:
  - M8x8: 00.
  - M16x16: crossed ? 11 : 00.
  - M32x16: crossed ? 01 : 10.
  - M32x32: 10 in MP_FIRST, 01 in MP_SECOND.
  - MP_ACCUM: 00.
- b_sign_en_o:
  - 0 in MP_FIRST when mode = M32x32, because the low half of B is unsigned.
  - 0 in MP_ACCUM.
  - 1 otherwise while mult_en_i is high.
- Transitions (only when mult_en_i = 1 and kill_i = 0):
  - MP_FIRST -> MP_SECOND if mode_i = M32x32.
  - MP_FIRST -> MP_ACCUM if accum_i = 1 (and mode_i is not M32x32).
  - MP_FIRST -> MP_FIRST otherwise, with valid_o = 1 in the same cycle.
  - MP_SECOND -> MP_ACCUM if accum_q_flag = 1.
  - MP_SECOND -> MP_FIRST otherwise, with valid_o = 1.
  - MP_ACCUM -> MP_FIRST, with valid_o = 1 and acc_phase_o = 1.
- Latency in cycles, including the request cycle:
  - 8x8/16x16/32x16: 1.
  - 32x32: 2.
  - Add 1 when accum.
  - Maximum is 3 (32x32 MAC).
- Accumulator register:
  - Loads partial_i in MP_FIRST when mult_en_i = 1, kill_i = 0 and (mode_i = M32x32 or accum_i = 1).
  - Loads partial_i in MP_SECOND when accum_q_flag = 1.
  - Holds in every other case, including MP_ACCUM, kill and stall.
- Stall: mult_en_i = 0 outside MP_FIRST holds state and the accumulator. Outputs stay stable and valid_o = 0.
- Kill: kill_i = 1 in any state:
  - valid_o is forced to 0 in that cycle.
  - Next state is MP_FIRST.
  - The accumulator does not load.
  - Simultaneous kill_i and mult_en_i resolves as kill.
- Back-to-back: a new request in the cycle after valid_o starts immediately in MP_FIRST. There are no bubbles.
- Asynchronous reset mid-operation: state returns to MP_FIRST immediately and the accumulator returns to ACC_RST_VAL. No valid_o is produced.
- Idle (mult_en_i = 0 in MP_FIRST): valid_o = 0, busy_o = 0, quadrant_o follows the decode, and b_sign_en_o = 0.

Decomposition:
- Add the typedef mult_pext_fsm_e {MP_FIRST, MP_SECOND, MP_ACCUM} to ibex_pkg_pext, next to mult_pext_mode_e.
- Add the quadrant constants QUAD_NORM = 2'b00, QUAD_CROSS = 2'b11, QUAD_ABOT = 2'b10, QUAD_ATOP = 2'b01 to the same package.
- Single module, no sub-module. The operator-to-mode decode stays in the datapath/decoder.

Test Plan:
- M16x16, crossed = 1, accum = 0, en for 1 cycle:
  - valid_o = 1 in cycle 0, quadrant_o = 11, busy_o = 0 throughout.
  - accum_q_o stays 0.
- M32x32, accum = 0, partial_i = 32'h1234_5678 in cycle 0:
  - cycle 0: quadrant_o = 10, b_sign_en_o = 0, valid_o = 0.
  - cycle 1: quadrant_o = 01, b_sign_en_o = 1, valid_o = 1, accum_q_o = 32'h1234_5678.
- M32x32 MAC, partial_i = 32'hA in cycle 0 and 32'hB in cycle 1:
  - valid_o = 1 only in cycle 2, with acc_phase_o = 1 and accum_q_o = 32'hB.
- M32x16 MAC; mode_i changed to M8x8 in cycle 1:
  - cycle 1 is MP_ACCUM with quadrant_o = 00.
  - valid_o = 1 in cycle 1; the latched mode is unaffected.
- M32x32 with mult_en_i dropped in cycle 1 for 2 cycles, then raised:
  - state holds MP_SECOND with busy_o = 1 and valid_o = 0.
  - valid_o = 1 on the cycle mult_en_i returns.
- kill_i in MP_SECOND of a 32x32 MAC:
  - no valid_o, state is MP_FIRST on the next cycle.
- rst_i pulse asserted asynchronously mid-cycle of a 32x32 op:
  - state is MP_FIRST and accum_q_o = ACC_RST_VAL immediately, with no clock edge needed.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// ibex_pkg_pext
//   Shared types and constants for the P-extension SIMD multiplier:
//   operating modes, the multi-pass sequencer states and the kernel
//   B-operand quadrant select encodings. No ports (package only).

package ibex_pkg_pext;

    // Multiplier operating mode as decoded from the operator in EX.
    typedef enum logic [1:0] {
        M8x8   = 2'b00,
        M16x16 = 2'b01,
        M32x16 = 2'b10,
        M32x32 = 2'b11
    } mult_pext_mode_e;

    // Multi-pass sequencer states.
    typedef enum logic [1:0] {
        MP_FIRST  = 2'b00,
        MP_SECOND = 2'b01,
        MP_ACCUM  = 2'b10
    } mult_pext_fsm_e;

    // Kernel B-operand quadrant selects.
    localparam logic [1:0] QUAD_NORM  = 2'b00;
    localparam logic [1:0] QUAD_CROSS = 2'b11;
    localparam logic [1:0] QUAD_ABOT  = 2'b10;
    localparam logic [1:0] QUAD_ATOP  = 2'b01;

    // Quadrant for a multiply pass. second_pass is only meaningful for
    // M32x32, which walks the low then the high half of B.
    function automatic logic [1:0] pext_quadrant(input mult_pext_mode_e mode,
                                                 input logic            crossed,
                                                 input logic            second_pass);
        logic [1:0] q;
        q = QUAD_NORM;
        unique case (mode)
            M8x8:    q = QUAD_NORM;
            M16x16:  q = crossed ? QUAD_CROSS : QUAD_NORM;
            M32x16:  q = crossed ? QUAD_ATOP  : QUAD_ABOT;
            M32x32:  q = second_pass ? QUAD_ATOP : QUAD_ABOT;
            default: q = QUAD_NORM;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/ibex_mult_pext_seq.sv
// ibex_mult_pext_seq
//   Sequencer for the P-extension SIMD multiplier datapath. Drives the kernel
//   quadrant select and B-operand sign enable each cycle, owns the 32-bit
//   accumulator register, sequences 32x32 two-pass and MAC operations and
//   flags the cycle on which the datapath result is final.
//
//   Ports:
//     clk_i        rising-edge clock
//     rst_i        asynchronous active-high reset
//     mult_en_i    request, held by EX until valid_o
//     kill_i       flush of the current operation (wins over mult_en_i)
//     mode_i       operating mode
//     crossed_i    crossed operand pairing
//     accum_i      MAC operation (extra accumulate cycle)
//     partial_i    datapath 32x16 upper word of the current pass
//     quadrant_o   kernel B-operand quadrant select
//     b_sign_en_o  kernel B-operand sign extension enable
//     acc_phase_o  datapath selects accumulator + rd_val
//     accum_q_o    accumulator register
//     busy_o       sequencer is not in MP_FIRST
//     valid_o      datapath result valid this cycle

module ibex_mult_pext_seq
    import ibex_pkg_pext::*;
#(
    parameter logic [31:0] ACC_RST_VAL = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mult_en_i,
    input  logic            kill_i,
    input  mult_pext_mode_e mode_i,
    input  logic            crossed_i,
    input  logic            accum_i,
    input  logic [31:0]     partial_i,
    output logic [1:0]      quadrant_o,
    output logic            b_sign_en_o,
    output logic            acc_phase_o,
    output logic [31:0]     accum_q_o,
    output logic            busy_o,
    output logic            valid_o
);

    mult_pext_fsm_e  state_q, state_d;
    mult_pext_mode_e mode_q, mode_d;
    logic            crossed_q, crossed_d;
    logic            accum_flag_q, accum_flag_d;
    logic [31:0]     acc_q, acc_d;

    logic            go;

    // A request only advances when not killed.
    assign go = mult_en_i & ~kill_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= MP_FIRST;
            mode_q       <= M8x8;
            crossed_q    <= 1'b0;
            accum_flag_q <= 1'b0;
            acc_q        <= ACC_RST_VAL;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            crossed_q    <= crossed_d;
            accum_flag_q <= accum_flag_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        crossed_d    = crossed_q;
        accum_flag_d = accum_flag_q;
        acc_d        = acc_q;
        quadrant_o   = QUAD_NORM;
        b_sign_en_o  = 1'b0;
        acc_phase_o  = 1'b0;
        valid_o      = 1'b0;

        unique case (state_q)
            MP_FIRST: begin
                // Controls decode straight from the inputs here; later
                // passes see only the copy latched on the request cycle.
                quadrant_o  = pext_quadrant(mode_i, crossed_i, 1'b0);
                // Low half of B is unsigned on the first 32x32 pass.
                b_sign_en_o = mult_en_i & (mode_i != M32x32);
                if (mult_en_i) begin
                    mode_d       = mode_i;
                    crossed_d    = crossed_i;
                    accum_flag_d = accum_i;
                end
                if (go) begin
                    if (mode_i == M32x32) begin
                        state_d = MP_SECOND;
                        acc_d   = partial_i;
                    end else if (accum_i) begin
                        state_d = MP_ACCUM;
                        acc_d   = partial_i;
                    end else begin
                        valid_o = 1'b1;
                    end
                end
            end
            MP_SECOND: begin
                // Outputs stay put across a stall; only advance is gated.
                quadrant_o  = pext_quadrant(mode_q, crossed_q, 1'b1);
                b_sign_en_o = 1'b1;
                if (go) begin
                    if (accum_flag_q) begin
                        state_d = MP_ACCUM;
                        acc_d   = partial_i;
                    end else begin
                        state_d = MP_FIRST;
                        valid_o = 1'b1;
                    end
                end
            end
            MP_ACCUM: begin
                quadrant_o  = QUAD_NORM;
                acc_phase_o = 1'b1;
                if (go) begin
                    state_d = MP_FIRST;
                    valid_o = 1'b1;
                end
            end
            default: begin
                state_d = MP_FIRST;
            end
        endcase

        if (kill_i) begin
            state_d = MP_FIRST;
        end
    end

    assign accum_q_o = acc_q;
    assign busy_o    = (state_q != MP_FIRST);

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
module tb_ibex_mult_pext_seq;
    import ibex_pkg_pext::*;

    localparam logic [31:0] RST_VAL = 32'hCAFE_0001;

    logic            clk;
    logic            rst;
    logic            mult_en;
    logic            kill;
    mult_pext_mode_e mode;
    logic            crossed;
    logic            accum;
    logic [31:0]     partial;
    logic [1:0]      quadrant;
    logic            b_sign_en;
    logic            acc_phase;
    logic [31:0]     accum_q;
    logic            busy;
    logic            valid;

    int checks = 0;
    int errors = 0;

    // {quadrant, b_sign_en, acc_phase, busy, valid}
    logic [5:0] ctl;
    assign ctl = {quadrant, b_sign_en, acc_phase, busy, valid};

    ibex_mult_pext_seq #(.ACC_RST_VAL(RST_VAL)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mult_en_i  (mult_en),
        .kill_i     (kill),
        .mode_i     (mode),
        .crossed_i  (crossed),
        .accum_i    (accum),
        .partial_i  (partial),
        .quadrant_o (quadrant),
        .b_sign_en_o(b_sign_en),
        .acc_phase_o(acc_phase),
        .accum_q_o  (accum_q),
        .busy_o     (busy),
        .valid_o    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic kl, input mult_pext_mode_e m,
                         input logic cr, input logic ac, input logic [31:0] p);
        mult_en = en; kill = kl; mode = m; crossed = cr; accum = ac; partial = p;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_0_0_0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b000000); end
        checks++;
        if (accum_q !== RST_VAL) begin errors++; $display("FAIL reset_acc got %h exp %h", accum_q, RST_VAL); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_0_0_0) begin errors++; $display("FAIL idle_ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle();
    endtask

    task automatic test_m16_crossed();
        drive(1'b1, 1'b0, M16x16, 1'b1, 1'b0, 32'h5555_AAAA);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b11_1_0_0_1) begin errors++; $display("FAIL m16x_c0 got %b exp %b", ctl, 6'b111001); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_0_0_0) begin errors++; $display("FAIL m16x_idle got %b exp %b", ctl, 6'b000000); end
        checks++;
        if (accum_q !== RST_VAL) begin errors++; $display("FAIL m16x_acc got %h exp %h", accum_q, RST_VAL); end
        next_cycle();
    endtask

    task automatic test_m32x32();
        drive(1'b1, 1'b0, M32x32, 1'b0, 1'b0, 32'h1234_5678);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b10_0_0_0_0) begin errors++; $display("FAIL m32_c0 got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        partial = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b01_1_0_1_1) begin errors++; $display("FAIL m32_c1 got %b exp %b", ctl, 6'b011011); end
        checks++;
        if (accum_q !== 32'h1234_5678) begin errors++; $display("FAIL m32_acc1 got %h exp %h", accum_q, 32'h1234_5678); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (accum_q !== 32'h1234_5678) begin errors++; $display("FAIL m32_acc_hold got %h exp %h", accum_q, 32'h1234_5678); end
        next_cycle();
    endtask

    task automatic test_m32x32_mac();
        drive(1'b1, 1'b0, M32x32, 1'b0, 1'b1, 32'hA);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b10_0_0_0_0) begin errors++; $display("FAIL mac_c0 got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        partial = 32'hB;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b01_1_0_1_0) begin errors++; $display("FAIL mac_c1 got %b exp %b", ctl, 6'b011010); end
        checks++;
        if (accum_q !== 32'hA) begin errors++; $display("FAIL mac_acc1 got %h exp %h", accum_q, 32'hA); end
        next_cycle();
        partial = 32'hC;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_1_1_1) begin errors++; $display("FAIL mac_c2 got %b exp %b", ctl, 6'b000111); end
        checks++;
        if (accum_q !== 32'hB) begin errors++; $display("FAIL mac_acc2 got %h exp %h", accum_q, 32'hB); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({busy, valid, accum_q} !== {2'b00, 32'hB}) begin
            errors++; $display("FAIL mac_after got busy=%b valid=%b acc=%h exp 0 0 %h", busy, valid, accum_q, 32'hB);
        end
        next_cycle();
    endtask

    task automatic test_m32x16_mac_latch();
        drive(1'b1, 1'b0, M32x16, 1'b0, 1'b1, 32'h0000_0005);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b10_1_0_0_0) begin errors++; $display("FAIL m3216_c0 got %b exp %b", ctl, 6'b101000); end
        next_cycle();
        mode = M8x8; crossed = 1'b1; accum = 1'b0; partial = 32'h0000_0009;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_1_1_1) begin errors++; $display("FAIL m3216_c1 got %b exp %b", ctl, 6'b000111); end
        checks++;
        if (accum_q !== 32'h5) begin errors++; $display("FAIL m3216_acc got %h exp %h", accum_q, 32'h5); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        next_cycle();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, M32x32, 1'b1, 1'b0, 32'h0BAD_F00D);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b10_0_0_0_0) begin errors++; $display("FAIL stall_c0 got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, M16x16, 1'b0, 1'b1, 32'h1111_2222 + 32'(i));
            @(negedge clk);
            checks++;
            if ({quadrant, acc_phase, busy, valid} !== 5'b01_0_1_0) begin
                errors++; $display("FAIL stall_hold%0d got %b exp %b", i, {quadrant, acc_phase, busy, valid}, 5'b01010);
            end
            checks++;
            if (accum_q !== 32'h0BAD_F00D) begin errors++; $display("FAIL stall_acc%0d got %h exp %h", i, accum_q, 32'h0BAD_F00D); end
            next_cycle();
        end
        mult_en = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b01_1_0_1_1) begin errors++; $display("FAIL stall_resume got %b exp %b", ctl, 6'b011011); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({busy, accum_q} !== {1'b0, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL stall_end got busy=%b acc=%h exp 0 %h", busy, accum_q, 32'h0BAD_F00D);
        end
        next_cycle();
    endtask

    task automatic test_kill();
        drive(1'b1, 1'b0, M32x32, 1'b0, 1'b1, 32'h0000_00AA);
        next_cycle();
        kill = 1'b1; partial = 32'h0000_00BB;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b01_1_0_1_0) begin errors++; $display("FAIL kill_c1 got %b exp %b", ctl, 6'b011010); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_0_0_0) begin errors++; $display("FAIL kill_after got %b exp %b", ctl, 6'b000000); end
        checks++;
        if (accum_q !== 32'hAA) begin errors++; $display("FAIL kill_acc got %h exp %h", accum_q, 32'hAA); end
        next_cycle();
        // Kill on the request cycle of a MAC: no load, no advance.
        drive(1'b1, 1'b1, M8x8, 1'b0, 1'b1, 32'h0000_00DD);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_1_0_0_0) begin errors++; $display("FAIL killf_c0 got %b exp %b", ctl, 6'b001000); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({busy, accum_q} !== {1'b0, 32'hAA}) begin
            errors++; $display("FAIL killf_after got busy=%b acc=%h exp 0 %h", busy, accum_q, 32'hAA);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_1_0_0_1) begin errors++; $display("FAIL b2b_c0 got %b exp %b", ctl, 6'b001001); end
        next_cycle();
        drive(1'b1, 1'b0, M32x16, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b01_1_0_0_1) begin errors++; $display("FAIL b2b_c1 got %b exp %b", ctl, 6'b011001); end
        next_cycle();
        drive(1'b1, 1'b0, M32x32, 1'b1, 1'b0, 32'hEEEE_0001);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b10_0_0_0_0) begin errors++; $display("FAIL b2b_c2 got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b01_1_0_1_1) begin errors++; $display("FAIL b2b_c3 got %b exp %b", ctl, 6'b011011); end
        next_cycle();
        drive(1'b1, 1'b0, M16x16, 1'b0, 1'b1, 32'hFFFF_000F);
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_1_0_0_0) begin errors++; $display("FAIL b2b_c4 got %b exp %b", ctl, 6'b001000); end
        checks++;
        if (accum_q !== 32'hEEEE_0001) begin errors++; $display("FAIL b2b_acc4 got %h exp %h", accum_q, 32'hEEEE_0001); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b00_0_1_1_1) begin errors++; $display("FAIL b2b_c5 got %b exp %b", ctl, 6'b000111); end
        checks++;
        if (accum_q !== 32'hFFFF_000F) begin errors++; $display("FAIL b2b_acc5 got %h exp %h", accum_q, 32'hFFFF_000F); end
        next_cycle();
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        next_cycle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, M32x32, 1'b0, 1'b1, 32'h0000_0077);
        next_cycle();
        checks++;
        if ({busy, accum_q} !== {1'b1, 32'h77}) begin
            errors++; $display("FAIL arst_pre got busy=%b acc=%h exp 1 %h", busy, accum_q, 32'h77);
        end
        #1;
        rst = 1'b1;
        mult_en = 1'b0;
        #1;
        checks++;
        if ({busy, valid, acc_phase} !== 3'b000) begin
            errors++; $display("FAIL arst_ctl got %b exp %b", {busy, valid, acc_phase}, 3'b000);
        end
        checks++;
        if (accum_q !== RST_VAL) begin errors++; $display("FAIL arst_acc got %h exp %h", accum_q, RST_VAL); end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, M8x8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({ctl, accum_q} !== {6'b000000, RST_VAL}) begin
            errors++; $display("FAIL arst_after got ctl=%b acc=%h exp 000000 %h", ctl, accum_q, RST_VAL);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_m16_crossed();
        test_m32x32();
        test_m32x32_mac();
        test_m32x16_mac_latch();
        test_stall();
        test_kill();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
